// File: rtl/dmem_responder.sv
// dmem_responder: dmem bus target driving a synchronous 64-bit SRAM with big-endian lane steering.
// Optional DMEM_ALIGN_CHECK_EN adds misalignment faulting (dmem_fault port); otherwise offsets are force-aligned.
`default_nettype none

module dmem_responder #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       dmem_addr,
  input  logic [63:0]       dmem_wdata,
  input  logic [1:0]        dmem_width,
  input  logic              dmem_rstrobe,
  input  logic              dmem_wstrobe,
  output logic [63:0]       dmem_rdata,
  output logic              dmem_cycle_complete,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic              dmem_fault,
`endif
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic [7:0]        sram_we,
  output logic [63:0]       sram_wdata,
  input  logic [63:0]       sram_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    RD_RESP  = 3'd3,
    WR_ISSUE = 3'd4,
    WR_RESP  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] word_q;
  logic [2:0]        off_q;
  logic [1:0]        width_q;
  logic [63:0]       wdata_q;
  logic [7:0]        mask_q;
  logic              is_rd_q;
  logic              fault_q;
  logic [1:0]        wait_cnt;
  logic [63:0]       rdata_q;

  logic [3:0]  size_bytes;
  logic [6:0]  size_bits;
  logic [6:0]  size_bits_q;
  logic [2:0]  off_raw;
  logic [2:0]  off_use;
  logic        misaligned;
  logic [7:0]  we_mask;
  logic [63:0] wdata_steer;
  logic [63:0] rdata_steer;
  logic        accept;
  logic        wr_active;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^dmem_addr[63:ADDR_W+3];

  assign size_bytes = 4'd8 >> dmem_width;
  assign size_bits  = 7'd64 >> dmem_width;
  assign size_bits_q = 7'd64 >> width_q;
  assign off_raw    = dmem_addr[2:0];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (off_raw & (size_bytes[2:0] - 3'd1)) != 3'd0;
  assign off_use    = off_raw;
`else
  assign misaligned = 1'b0;
  assign off_use    = off_raw & ~(size_bytes[2:0] - 3'd1);
`endif

  // Byte k lives at bits [63-8k -: 8], so byte-enable bit (7-k) and MSB-first data placement.
  assign we_mask     = (8'hFF << (4'd8 - size_bytes)) >> off_use;
  assign wdata_steer = ((dmem_wdata & (~64'h0 >> (7'd64 - size_bits))) << (7'd64 - size_bits))
                       >> {off_use, 3'b000};
  assign rdata_steer = (sram_rdata << {off_q, 3'b000}) & (~64'h0 << (7'd64 - size_bits_q));

  assign accept = (state == IDLE) && (dmem_rstrobe || dmem_wstrobe);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_q   <= '0;
      off_q    <= '0;
      width_q  <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      is_rd_q  <= 1'b0;
      fault_q  <= 1'b0;
      wait_cnt <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        word_q  <= dmem_addr[ADDR_W+2:3];
        off_q   <= off_use;
        width_q <= dmem_width;
        wdata_q <= wdata_steer;
        mask_q  <= we_mask;
        is_rd_q <= dmem_rstrobe;
        fault_q <= misaligned;
      end
      if (state == RD_WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (state == RD_WAIT && wait_cnt == 2'(RD_LAT - 1)) begin
        rdata_q <= rdata_steer;
      end else if (state == WR_ISSUE && fault_q && is_rd_q) begin
        rdata_q <= '0;
      end
    end
  end

  // Faulted accesses (reads included) take the short issue/response path with the SRAM idle.
  assign wr_active = (state == WR_ISSUE) && !fault_q && !is_rd_q;

  always_comb begin
    state_next          = state;
    sram_en             = 1'b0;
    sram_we             = 8'h00;
    dmem_cycle_complete = 1'b0;
    case (state)
      IDLE: begin
        if (dmem_rstrobe) begin
          state_next = misaligned ? WR_ISSUE : RD_ISSUE;
        end else if (dmem_wstrobe) begin
          state_next = WR_ISSUE;
        end
      end
      RD_ISSUE: begin
        sram_en    = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_cnt == 2'(RD_LAT - 1)) state_next = RD_RESP;
      end
      RD_RESP: begin
        dmem_cycle_complete = 1'b1;
        state_next          = IDLE;
      end
      WR_ISSUE: begin
        sram_en    = wr_active;
        sram_we    = wr_active ? mask_q : 8'h00;
        state_next = WR_RESP;
      end
      WR_RESP: begin
        dmem_cycle_complete = 1'b1;
        state_next          = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sram_addr  = word_q;
  assign sram_wdata = wdata_q;
  assign dmem_rdata = rdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
  assign dmem_fault = (state == WR_RESP) && fault_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven directed vectors plus hand sequences for arbitration and reset.
`default_nettype none

module tb_dmem_responder;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [63:0]       dmem_addr = '0;
  logic [63:0]       dmem_wdata = '0;
  logic [1:0]        dmem_width = '0;
  logic              dmem_rstrobe = 1'b0;
  logic              dmem_wstrobe = 1'b0;
  logic [63:0]       dmem_rdata;
  logic              dmem_cycle_complete;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic [7:0]        sram_we;
  logic [63:0]       sram_wdata;
  logic [63:0]       sram_rdata = '0;
  logic              fault_w;

  int passed = 0;
  int total  = 0;

  dmem_responder #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_width          (dmem_width),
    .dmem_rstrobe        (dmem_rstrobe),
    .dmem_wstrobe        (dmem_wstrobe),
    .dmem_rdata          (dmem_rdata),
    .dmem_cycle_complete (dmem_cycle_complete),
`ifdef DMEM_ALIGN_CHECK_EN
    .dmem_fault          (fault_w),
`endif
    .sram_addr           (sram_addr),
    .sram_en             (sram_en),
    .sram_we             (sram_we),
    .sram_wdata          (sram_wdata),
    .sram_rdata          (sram_rdata)
  );

`ifndef DMEM_ALIGN_CHECK_EN
  assign fault_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // One-cycle-latency SRAM model
  logic [63:0] mem [16];
  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 8; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [1:0] w, input logic [63:0] wd,
                        output int lat, output logic en_s, output logic [7:0] we_s,
                        output logic [63:0] wd_s, output logic [63:0] rd_s,
                        output logic fault_s, output logic pulse_ok);
    @(negedge clk);
    dmem_rstrobe = rd; dmem_wstrobe = wr;
    dmem_addr = addr; dmem_width = w; dmem_wdata = wd;
    @(negedge clk);
    en_s = sram_en; we_s = sram_we; wd_s = sram_wdata;
    dmem_rstrobe = 1'b0; dmem_wstrobe = 1'b0;
    dmem_addr = {$urandom, $urandom}; dmem_wdata = {$urandom, $urandom};
    dmem_width = 2'($urandom);
    lat = 1;
    while (!dmem_cycle_complete && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd_s = dmem_rdata; fault_s = fault_w;
    @(negedge clk);
    pulse_ok = !dmem_cycle_complete;
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic [63:0] addr;
    logic [1:0]  width;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic [7:0]  exp_we;
    logic [63:0] exp_wd;
  } vec_t;

  vec_t vecs [12];

  int          lat;
  logic        en_s, fault_s, pulse_ok;
  logic [7:0]  we_s;
  logic [63:0] wd_s, rd_s;
  int          cnt_en, cnt_cmp;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 64'h0;
    mem[2] = 64'h0011223344556677;
    mem[5] = 64'h8877665544332211;

    vecs[0]  = '{"rd64_0x10", 1, 64'h10, 2'd0, 0, 64'h0011223344556677, 8'h00, 0};
    vecs[1]  = '{"rd8_0x13",  1, 64'h13, 2'd3, 0, 64'h3300000000000000, 8'h00, 0};
    vecs[2]  = '{"rd32_0x14", 1, 64'h14, 2'd1, 0, 64'h4455667700000000, 8'h00, 0};
    vecs[3]  = '{"wr16_0x12", 0, 64'h12, 2'd2, 64'hFFFFFFFFFFFFBEEF, 0, 8'h30, 64'h0000BEEF00000000};
    vecs[4]  = '{"rd64_back", 1, 64'h10, 2'd0, 0, 64'h0011BEEF44556677, 8'h00, 0};
    vecs[5]  = '{"rd16_alias",1, 64'h92, 2'd2, 0, 64'hBEEF000000000000, 8'h00, 0};
    vecs[6]  = '{"wr8_0x17",  0, 64'h17, 2'd3, 64'hFFFFFFFFFFFFFFAA, 0, 8'h01, 64'h00000000000000AA};
    vecs[7]  = '{"rd8_0x17",  1, 64'h17, 2'd3, 0, 64'hAA00000000000000, 8'h00, 0};
    vecs[8]  = '{"rd64_0x28", 1, 64'h28, 2'd0, 0, 64'h8877665544332211, 8'h00, 0};
    vecs[9]  = '{"rd8_0x2F",  1, 64'h2F, 2'd3, 0, 64'h1100000000000000, 8'h00, 0};
    vecs[10] = '{"wr64_0x28", 0, 64'h28, 2'd0, 64'hDEADBEEFCAFEF00D, 0, 8'hFF, 64'hDEADBEEFCAFEF00D};
    vecs[11] = '{"rd32_0x2C", 1, 64'h2C, 2'd1, 0, 64'hCAFEF00D00000000, 8'h00, 0};

    repeat (3) @(negedge clk);
    chk("reset_rdata",    dmem_rdata, 64'h0);
    chk("reset_complete", 64'(dmem_cycle_complete), 64'h0);
    chk("reset_en",       64'(sram_en), 64'h0);
    chk("reset_we",       64'(sram_we), 64'h0);
    chk("reset_addr",     64'(sram_addr), 64'h0);
    chk("reset_wdata",    sram_wdata, 64'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      access(vecs[i].rd, !vecs[i].rd, vecs[i].addr, vecs[i].width, vecs[i].wdata,
             lat, en_s, we_s, wd_s, rd_s, fault_s, pulse_ok);
      chk({vecs[i].name, "_lat"},   64'(lat), vecs[i].rd ? 64'd3 : 64'd2);
      chk({vecs[i].name, "_en"},    64'(en_s), 64'h1);
      chk({vecs[i].name, "_we"},    64'(we_s), 64'(vecs[i].exp_we));
      chk({vecs[i].name, "_pulse"}, 64'(pulse_ok), 64'h1);
      if (vecs[i].rd) chk({vecs[i].name, "_rdata"}, rd_s, vecs[i].exp_rdata);
      else            chk({vecs[i].name, "_wdata"}, wd_s, vecs[i].exp_wd);
    end

    // Both strobes together: the read wins and the word is left alone
    access(1, 1, 64'h10, 2'd0, 64'h0, lat, en_s, we_s, wd_s, rd_s, fault_s, pulse_ok);
    chk("both_lat",   64'(lat), 64'd3);
    chk("both_we",    64'(we_s), 64'h0);
    chk("both_rdata", rd_s, 64'h0011BEEF445566AA);

    // Write strobe during RD_WAIT must be ignored
    @(negedge clk);
    dmem_rstrobe = 1'b1; dmem_addr = 64'h10; dmem_width = 2'd0;
    @(negedge clk);
    dmem_rstrobe = 1'b0;
    @(negedge clk);
    dmem_wstrobe = 1'b1; dmem_addr = 64'h10; dmem_width = 2'd0; dmem_wdata = 64'h0;
    @(negedge clk);
    dmem_wstrobe = 1'b0;
    chk("busy_complete", 64'(dmem_cycle_complete), 64'h1);
    chk("busy_rdata",    dmem_rdata, 64'h0011BEEF445566AA);
    cnt_en = 0; cnt_cmp = 0;
    repeat (4) begin
      @(negedge clk);
      if (sram_en) cnt_en++;
      if (dmem_cycle_complete) cnt_cmp++;
    end
    chk("busy_no_en",  64'(cnt_en), 64'h0);
    chk("busy_no_cmp", 64'(cnt_cmp), 64'h0);

    // Reset during RD_WAIT aborts the read
    @(negedge clk);
    dmem_rstrobe = 1'b1; dmem_addr = 64'h10; dmem_width = 2'd0;
    @(negedge clk);
    dmem_rstrobe = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rdata",    dmem_rdata, 64'h0);
    chk("rst_mid_complete", 64'(dmem_cycle_complete), 64'h0);
    chk("rst_mid_en",       64'(sram_en), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_cmp = 0;
    repeat (5) begin
      @(negedge clk);
      if (dmem_cycle_complete) cnt_cmp++;
    end
    chk("rst_no_cmp", 64'(cnt_cmp), 64'h0);
    access(1, 0, 64'h10, 2'd0, 64'h0, lat, en_s, we_s, wd_s, rd_s, fault_s, pulse_ok);
    chk("rst_after_lat",   64'(lat), 64'd3);
    chk("rst_after_rdata", rd_s, 64'h0011BEEF445566AA);

`ifdef DMEM_ALIGN_CHECK_EN
    access(0, 1, 64'h12, 2'd1, 64'h12345678, lat, en_s, we_s, wd_s, rd_s, fault_s, pulse_ok);
    chk("mis_wr_lat",   64'(lat), 64'd2);
    chk("mis_wr_en",    64'(en_s), 64'h0);
    chk("mis_wr_fault", 64'(fault_s), 64'h1);
    access(1, 0, 64'h15, 2'd2, 64'h0, lat, en_s, we_s, wd_s, rd_s, fault_s, pulse_ok);
    chk("mis_rd_lat",   64'(lat), 64'd2);
    chk("mis_rd_fault", 64'(fault_s), 64'h1);
    chk("mis_rd_rdata", rd_s, 64'h0);
    access(1, 0, 64'h10, 2'd0, 64'h0, lat, en_s, we_s, wd_s, rd_s, fault_s, pulse_ok);
    chk("mis_back",     rd_s, 64'h0011BEEF445566AA);
    chk("ok_rd_fault",  64'(fault_s), 64'h0);
`else
    access(0, 1, 64'h12, 2'd1, 64'h12345678, lat, en_s, we_s, wd_s, rd_s, fault_s, pulse_ok);
    chk("force_wr_lat",   64'(lat), 64'd2);
    chk("force_wr_we",    64'(we_s), 64'hF0);
    chk("force_wr_wdata", wd_s, 64'h1234567800000000);
    access(1, 0, 64'h10, 2'd0, 64'h0, lat, en_s, we_s, wd_s, rd_s, fault_s, pulse_ok);
    chk("force_back",     rd_s, 64'h12345678445566AA);
    access(1, 0, 64'h15, 2'd2, 64'h0, lat, en_s, we_s, wd_s, rd_s, fault_s, pulse_ok);
    chk("force_rd16",     rd_s, 64'h4455000000000000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
